// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO registers.
// Optional macro MULDIV_EARLY_OUT_EN: multiplies finish once the remaining multiplier is zero.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DZERO = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 op_div_q, op_div_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic [WIDTH-1:0]     a_raw_q, a_raw_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 dz_q, dz_d;

    logic                 is_signed;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       rem_sh;
    logic                 rem_ge;

    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? ({(2*WIDTH){1'b0}} - v) : v;
    endfunction

    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
        return cond_neg_w(v, v[WIDTH-1]);
    endfunction

    always_comb begin
        state_d   = state_q;
        op_div_d  = op_div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        a_raw_d   = a_raw_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;
        is_signed = ~op[0];
        abs_a     = is_signed ? abs_w(a) : a;
        abs_b     = is_signed ? abs_w(b) : b;
        rem_sh    = {rem_q, quo_q[WIDTH-1]};
        rem_ge    = (rem_sh >= {1'b0, divisor_q});

        case (state_q)
            IDLE: begin
                if (mthi) hi_d = wdata;
                if (mtlo) lo_d = wdata;
                if (start) begin
                    op_div_d  = op[1];
                    a_raw_d   = a;
                    neg_quo_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = is_signed & a[WIDTH-1];
                    acc_d     = '0;
                    mcand_d   = {{WIDTH{1'b0}}, abs_a};
                    mplier_d  = abs_b;
                    rem_d     = '0;
                    quo_d     = abs_a;
                    divisor_d = abs_b;
                    cnt_d     = '0;
                    state_d   = (op[1] && (b == '0)) ? DZERO : CALC;
                end
            end

            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (!op_div_q) begin
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end else begin
                    // Restoring step: the shifted remainder needs WIDTH+1 bits before the compare.
                    quo_d = {quo_q[WIDTH-2:0], rem_ge};
                    rem_d = rem_ge ? WIDTH'(rem_sh - {1'b0, divisor_q}) : rem_sh[WIDTH-1:0];
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIXUP;
`ifdef MULDIV_EARLY_OUT_EN
                if (!op_div_q && ((mplier_q >> 1) == '0)) state_d = FIXUP;
`endif
            end

            FIXUP: begin
                if (!op_div_q) begin
                    {hi_d, lo_d} = cond_neg_2w(acc_q, neg_quo_q);
                end else begin
                    lo_d = cond_neg_w(quo_q, neg_quo_q);
                    hi_d = cond_neg_w(rem_q, neg_rem_q);
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end

            DZERO: begin
                lo_d    = '1;
                hi_d    = a_raw_q;
                done_d  = 1'b1;
                dz_d    = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            a_raw_q   <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_div_q  <= op_div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            a_raw_q   <= a_raw_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: randomized traffic against an arithmetic reference, plus directed literal cases.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int n_total = 0;
    int n_pass  = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int MULT_LAT = 5;
`else
    localparam int MULT_LAT = 34;
`endif

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference: result of one operation from plain arithmetic.
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } res_t;

    function automatic res_t golden(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        res_t r;
        logic signed [63:0] sx, sy, sp, sq, sr;
        logic [63:0] up;
        sx = $signed(x);
        sy = $signed(y);
        r.dz = 1'b0;
        r.hi = '0;
        r.lo = '0;
        case (o)
            2'b00: begin sp = sx * sy; r.hi = sp[63:32]; r.lo = sp[31:0]; end
            2'b01: begin up = {32'd0, x} * {32'd0, y}; r.hi = up[63:32]; r.lo = up[31:0]; end
            default: begin
                if (y == 32'd0) begin
                    r.dz = 1'b1; r.hi = x; r.lo = 32'hFFFF_FFFF;
                end else if (o == 2'b10) begin
                    sq = sx / sy; sr = sx % sy;
                    r.lo = sq[31:0]; r.hi = sr[31:0];
                end else begin
                    r.lo = x / y; r.hi = x % y;
                end
            end
        endcase
        return r;
    endfunction

    // Edges after the start edge until the done edge.
    function automatic int lat_of(input logic [1:0] o, input logic [31:0] y);
        if (o[1] && y == 32'd0) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!o[1]) begin
            logic [31:0] mag;
            int n;
            mag = (o == 2'b00 && y[31]) ? (32'd0 - y) : y;
            n = 1;
            for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
            return n + 1;
        end
`endif
        return 33;
    endfunction

    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_done = 1'b0, m_dz = 1'b0;
    res_t        m_pend = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0; m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_dz <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (m_left == 0) begin
                if (mthi) m_hi <= wdata;
                if (mtlo) m_lo <= wdata;
                if (start) begin
                    m_pend <= golden(op, a, b);
                    m_left <= lat_of(op, b);
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi   <= m_pend.hi;
                    m_lo   <= m_pend.lo;
                    m_done <= 1'b1;
                    m_dz   <= m_pend.dz;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m_left != 0));
        chk("done", 64'(done), 64'(m_done));
        chk("div_zero", 64'(div_zero), 64'(m_dz));
        chk("hi", 64'(hi), 64'(m_hi));
        chk("lo", 64'(lo), 64'(m_lo));
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit glitch, input logic [31:0] hold_lo,
                         output int lat, output int bcnt, output bit dzs);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        lat = 0; bcnt = 0; dzs = 1'b0;
        for (int e = 1; e <= 100; e++) begin
            @(posedge clk); #1;
            if (e == 1) start = 1'b0;
            if (busy) bcnt++;
            if (glitch && e == 5) begin
                start = 1'b1; op = 2'b01; a = $urandom; b = $urandom;
                mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            if (glitch && e == 6) begin
                start = 1'b0; mtlo = 1'b0;
                chk("lo_hold_busy", 64'(lo), 64'(hold_lo));
            end
            if (done) begin
                lat = e; dzs = div_zero;
                break;
            end
        end
    endtask

    task automatic mt_write(input bit to_hi, input logic [31:0] v);
        @(negedge clk);
        mthi = to_hi; mtlo = ~to_hi; wdata = v;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, bcnt, nd;
        bit dzs;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        mt_write(1'b1, 32'hA5A5_A5A5);
        chk("mthi", 64'(hi), 64'hA5A5_A5A5);
        mt_write(1'b0, 32'h5A5A_5A5A);
        chk("mtlo", 64'(lo), 64'h5A5A_5A5A);

        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '0, lat, bcnt, dzs);
        chk("multu_lat", 64'(lat), 64'd34);
        chk("multu_busy_cycles", 64'(bcnt), 64'd33);
        chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(lo), 64'h0000_0001);

        do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, '0, lat, bcnt, dzs);
        chk("mult_b2b_lat", 64'(lat), 64'(MULT_LAT));
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);

        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, '0, lat, bcnt, dzs);
        chk("div_lat", 64'(lat), 64'd34);
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);

        do_op(2'b11, 32'd7, 32'd2, 1'b1, 32'hFFFF_FFFD, lat, bcnt, dzs);
        chk("divu_glitch_lat", 64'(lat), 64'd34);
        chk("divu_lo", 64'(lo), 64'd3);
        chk("divu_hi", 64'(hi), 64'd1);

        do_op(2'b11, 32'h0000_1234, 32'd0, 1'b0, '0, lat, bcnt, dzs);
        chk("dz_lat", 64'(lat), 64'd2);
        chk("dz_flag", 64'(dzs), 64'd1);
        chk("dz_hi", 64'(hi), 64'h0000_1234);
        chk("dz_lo", 64'(lo), 64'hFFFF_FFFF);

        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, '0, lat, bcnt, dzs);
        chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
        chk("div_ovf_hi", 64'(hi), 64'd0);

        mt_write(1'b1, 32'h1111_2222);
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'h0000_FFFF; b = 32'h0000_1234;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        chk("abort_no_done", 64'(nd), 64'd0);

        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 5) == 0);
            op    = 2'($urandom_range(0, 3));
            a     = pick();
            b     = pick();
            mthi  = ($urandom_range(0, 9) == 0);
            mtlo  = ($urandom_range(0, 9) == 0);
            wdata = $urandom;
        end
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        nd = 0;
        while (busy && nd < 100) begin
            @(negedge clk);
            nd++;
        end
        chk("drain_idle", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
